// File: rtl/bus_ack_responder.sv
// bus_ack_responder: memory-side end of the CPU four-phase req/ack handshake.
// Serves reads/writes to an internal word memory after WAIT programmable wait states.
`default_nettype none

module bus_ack_responder #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int WAIT   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              stall,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              err
);

  localparam int         DEPTH  = 2 ** ADDR_W;
  localparam logic [3:0] WAIT_C = 4'(WAIT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAITS   = 2'd1,
    S_ACKED   = 2'd2,
    S_RELEASE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                ack_q, ack_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                commit_en;
  logic                commit_we;
  logic [ADDR_W-1:0]   commit_addr;
  logic [DATA_W-1:0]   commit_wdata;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    ack_d        = ack_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    commit_en    = 1'b0;
    commit_we    = we_q;
    commit_addr  = addr_q;
    commit_wdata = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = WAIT_C;
          if (WAIT_C == 4'd0) begin
            // Zero wait states: the latch edge is also the commit edge, so use the live inputs.
            state_d      = S_ACKED;
            ack_d        = 1'b1;
            commit_en    = 1'b1;
            commit_we    = we;
            commit_addr  = addr;
            commit_wdata = wdata;
          end else begin
            state_d = S_WAITS;
          end
        end
      end
      S_WAITS: begin
        if (!req) begin
          // Abort outranks stall: requester gave up before ack.
          err_d   = 1'b1;
          cnt_d   = 4'd0;
          state_d = S_IDLE;
        end else if (!stall) begin
          if (cnt_q <= 4'd1) begin
            cnt_d     = 4'd0;
            state_d   = S_ACKED;
            ack_d     = 1'b1;
            commit_en = 1'b1;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      S_ACKED: begin
        if (!req) begin
          ack_d   = 1'b0;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        state_d = S_IDLE;
      end
      default: begin
        ack_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    if (commit_en && !commit_we) begin
      rdata_d = mem_q[commit_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Memory is never cleared; reset only blocks a commit on its own edge.
  always_ff @(posedge clk) begin
    if (!reset && commit_en && commit_we) begin
      mem_q[commit_addr] <= commit_wdata;
    end
  end

  assign ack   = ack_q;
  assign rdata = rdata_q;
  assign busy  = (state_q != S_IDLE);
  assign err   = err_q;

endmodule

`default_nettype wire
